// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
//   state_e   : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_width : width of a counter that must hold 0..n-1 (at least one bit)
package piso_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // A counter for n == 1 still needs one bit so the register is never zero-width.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_tick.sv
// Bit-period timer for piso_tx.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   run   : count while high; counter is held at 0 while low
//   tick  : high on the last cycle of every DIV-cycle period while run=1
module tick_gen
  import piso_tx_pkg::*;
#(
  parameter int unsigned DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  // With DIV=1 CntMax is 0, so tick stays high for as long as run is high.
  assign tick = run && (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, each bit held DIV cycles.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset; all outputs low while asserted
//   load_valid : parallel word offered
//   load_data  : parallel word, captured only on acceptance
//   load_ready : registered; high in IDLE (from the first edge after reset)
//   ser_out    : serial line, taken straight from the shift register MSB
//   ser_frame  : registered; high for the WIDTH*DIV cycles of a frame
//   done       : registered one-cycle pulse after the final bit period
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             done
);

  localparam int unsigned BitW = cnt_width(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic             load_ready_q;
  logic             ser_frame_q;
  logic             done_q;
  logic             tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == StShift),
    .tick  (tick)
  );

  // Zeros shift in behind the data, so after WIDTH shifts the register is
  // empty again and its MSB doubles as a ser_out that is low outside frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      load_ready_q <= 1'b0;
      ser_frame_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (load_valid && load_ready_q) begin
            shreg_q      <= load_data;
            bit_cnt_q    <= '0;
            load_ready_q <= 1'b0;
            ser_frame_q  <= 1'b1;
            state_q      <= StShift;
          end else begin
            load_ready_q <= 1'b1;
            ser_frame_q  <= 1'b0;
          end
        end
        StShift: begin
          if (tick) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q   <= '0;
              ser_frame_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
        StDone: begin
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign ser_out    = shreg_q[WIDTH-1];
  assign ser_frame  = ser_frame_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three instances (8/12, 8/1, 2/3) checked
// every cycle against a frame-timing reference model plus a mid-bit sampling
// scoreboard that rebuilds each word from ser_out.
module tb_piso_tx;

  localparam int NI = 3;

  function automatic int unsigned w_of(int i);
    case (i)
      0:       return 8;
      1:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned d_of(int i);
    case (i)
      0:       return 12;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  load_valid = '0;
  logic [31:0] load_data [NI];
  logic [2:0]  load_ready;
  logic [2:0]  ser_out;
  logic [2:0]  ser_frame;
  logic [2:0]  done;

  piso_tx #(.WIDTH(8), .DIV(12)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid[0]),
    .load_data  (load_data[0][7:0]),
    .load_ready (load_ready[0]),
    .ser_out    (ser_out[0]),
    .ser_frame  (ser_frame[0]),
    .done       (done[0])
  );

  piso_tx #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid[1]),
    .load_data  (load_data[1][7:0]),
    .load_ready (load_ready[1]),
    .ser_out    (ser_out[1]),
    .ser_frame  (ser_frame[1]),
    .done       (done[1])
  );

  piso_tx #(.WIDTH(2), .DIV(3)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid[2]),
    .load_data  (load_data[2][1:0]),
    .load_ready (load_ready[2]),
    .ser_out    (ser_out[2]),
    .ser_frame  (ser_frame[2]),
    .done       (done[2])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: after an acceptance edge, cycles 1..W*D carry the frame,
  // cycle W*D+1 is the done cycle, then the block is idle and ready.
  bit          live [NI];
  bit          busy [NI];
  int unsigned ncyc [NI];
  logic [31:0] word [NI];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          live[i] = 1'b0;
          busy[i] = 1'b0;
          ncyc[i] = 0;
        end else if (!live[i]) begin
          live[i] = 1'b1;
        end else if (busy[i]) begin
          ncyc[i]++;
          if (ncyc[i] == w_of(i) * d_of(i) + 2) begin
            busy[i] = 1'b0;
            ncyc[i] = 0;
          end
        end else if (load_valid[i]) begin
          busy[i] = 1'b1;
          ncyc[i] = 1;
          word[i] = load_data[i] & mask_of(w_of(i));
        end
      end
    end
  end

  // Per-cycle output check and mid-bit reconstruction scoreboard.
  logic [31:0] rec  [NI];
  int          fcyc [NI];
  int          nbit [NI];
  bit          pfr  [NI];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int unsigned w;
        int unsigned d;
        logic [3:0]  exp;
        w = w_of(i);
        d = d_of(i);
        if (!live[i]) begin
          exp = 4'b0000;
        end else if (busy[i] && ncyc[i] <= w * d) begin
          exp = {3'b010, word[i][w - 1 - (ncyc[i] - 1) / d]};
        end else if (busy[i]) begin
          exp = 4'b0010;
        end else begin
          exp = 4'b1000;
        end
        check_eq($sformatf("outs%0d{rdy,frm,done,ser}", i),
                 {28'b0, load_ready[i], ser_frame[i], done[i], ser_out[i]}, {28'b0, exp});

        if (!rst_n) begin
          rec[i]  = '0;
          fcyc[i] = 0;
          nbit[i] = 0;
          pfr[i]  = 1'b0;
        end else begin
          if (ser_frame[i]) begin
            if ((fcyc[i] % d) == d / 2) begin
              rec[i] = {rec[i][30:0], ser_out[i]};
              nbit[i]++;
            end
            fcyc[i]++;
          end else if (pfr[i]) begin
            check_eq($sformatf("recon%0d", i), rec[i] & mask_of(w), word[i]);
            check_eq($sformatf("nbits%0d", i), nbit[i], w);
            rec[i]  = '0;
            fcyc[i] = 0;
            nbit[i] = 0;
          end
          pfr[i] = ser_frame[i];
        end
      end
    end
  end

  // Stimulus runs at posedge+1, so inputs are stable around every edge.
  task automatic wait_ready(int i);
    int k;
    k = 0;
    while (!load_ready[i] && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq($sformatf("ready_wait%0d", i), load_ready[i], 1);
  endtask

  task automatic send(int i, logic [31:0] d);
    wait_ready(i);
    load_valid[i] = 1'b1;
    load_data[i]  = d;
    @(posedge clk);
    #1;
    load_valid[i] = 1'b0;
    load_data[i]  = $urandom;
  endtask

  // Called at cycle 1 after acceptance; k numbers cycles after acceptance.
  task automatic measure(int i, output int fcnt, output int dcnt, output int dlat);
    fcnt = 0;
    dcnt = 0;
    dlat = 0;
    for (int k = 1; k <= 2000; k++) begin
      if (ser_frame[i]) fcnt++;
      if (done[i]) begin
        dcnt++;
        if (dlat == 0) dlat = k;
      end
      if (load_ready[i]) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_run(int i, int frames);
    int acc;
    acc = 0;
    for (int c = 0; c < 30000 && acc < frames; c++) begin
      load_data[i]  = $urandom;
      load_valid[i] = ($urandom_range(7) != 0);
      if (load_valid[i] && load_ready[i]) acc++;
      @(posedge clk);
      #1;
    end
    load_valid[i] = 1'b0;
    check_eq($sformatf("frames%0d", i), acc, frames);
  endtask

  initial begin
    int fcnt;
    int dcnt;
    int dlat;
    int cnt;
    for (int i = 0; i < NI; i++) load_data[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs0", {load_ready[0], ser_frame[0], done[0], ser_out[0]}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready0", load_ready[0], 1);

    // 8'hA5 at DIV=12
    send(0, 32'hA5);
    measure(0, fcnt, dcnt, dlat);
    check_eq("a5_frame_cycles", fcnt, 96);
    check_eq("a5_done_count", dcnt, 1);
    check_eq("a5_done_latency", dlat, 97);

    // 8'h81 at DIV=1
    send(1, 32'h81);
    measure(1, fcnt, dcnt, dlat);
    check_eq("d1_frame_cycles", fcnt, 8);
    check_eq("d1_done_latency", dlat, 9);

    // 2'b10 at WIDTH=2, DIV=3
    send(2, 32'h2);
    measure(2, fcnt, dcnt, dlat);
    check_eq("w2_frame_cycles", fcnt, 6);
    check_eq("w2_done_count", dcnt, 1);
    check_eq("w2_done_latency", dlat, 7);

    // load_valid held high: FF accepted, data switched to 00 mid-frame.
    wait_ready(0);
    load_valid[0] = 1'b1;
    load_data[0]  = 32'hFF;
    @(posedge clk);
    #1;
    load_data[0] = 32'h00;
    cnt = 0;
    while (!load_ready[0] && cnt < 500) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("b2b_spacing", cnt + 1, 8 * 12 + 2);
    @(posedge clk);
    #1;
    load_valid[0] = 1'b0;
    wait_ready(0);

    // Reset during bit 3 of 8'h3C: this leaves us at the start of cycle 42.
    send(0, 32'h3C);
    repeat (41) @(posedge clk);
    #2;
    check_eq("pre_rst_bit3", ser_out[0], 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs", {load_ready[0], ser_frame[0], done[0], ser_out[0]}, 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", load_ready[0], 1);
    check_eq("post_rst_done", done[0], 0);
    send(0, 32'hC3);
    measure(0, fcnt, dcnt, dlat);
    check_eq("c3_done_count", dcnt, 1);

    fork
      random_run(0, 40);
      random_run(1, 1000);
      random_run(2, 300);
    join

    for (int i = 0; i < NI; i++) wait_ready(i);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame; legal range 2..32.
REQ-002 Parameter DIV, default 12, clock cycles each serial bit is held; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 load_valid  input  1  parallel word offered for transmission.
REQ-006 load_data  input  WIDTH  parallel word; sampled only on acceptance.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  serial data line, MSB first.
REQ-009 ser_frame  output  1  high while a frame's bits are on ser_out.
REQ-010 done  output  1  one-cycle pulse after the last bit period ends.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: load_ready=1, ser_frame=0, ser_out=0, done=0.
REQ-013 Acceptance SHALL occur on a rising edge where load_valid=1 and load_ready=1; load_data is copied into an internal WIDTH-bit shift register.
REQ-014 The cycle after acceptance SHALL be in SHIFT with ser_out=load_data[WIDTH-1], ser_frame=1, load_ready=0.
REQ-015 In SHIFT each bit SHALL be held on ser_out for exactly DIV consecutive cycles, then the next lower bit is presented.
REQ-016 Bit order SHALL be load_data[WIDTH-1] down to load_data[0]; SHIFT lasts exactly WIDTH*DIV cycles.
REQ-017 After the final bit period the FSM SHALL enter DONE for exactly one cycle: done=1, ser_frame=0, ser_out=0, load_ready=0.
REQ-018 DONE SHALL always return to IDLE; minimum acceptance-to-acceptance spacing is WIDTH*DIV+2 cycles.
REQ-019 load_valid and load_data SHALL be ignored outside IDLE; changes to load_data after acceptance have no effect on the frame.
REQ-020 The bit-period counter SHALL count 0..DIV-1 and wrap to 0 on the cycle the bit advances; with DIV=1 the bit advances every cycle.
REQ-021 The bit counter SHALL count 0..WIDTH-1; no bit is repeated or skipped at counter wrap.
REQ-022 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-023 Asserting rst_n low SHALL immediately force IDLE, load_ready=1 is not required during reset; outputs SHALL be ser_out=0, ser_frame=0, done=0, load_ready=0 while rst_n=0.
REQ-024 After rst_n deasserts, load_ready SHALL be 1 from the first rising edge and the block is in IDLE.
REQ-025 Reset mid-frame SHALL abandon the frame with no done pulse; counters and shift register clear to 0.

Structure
REQ-026 The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in shared package piso_tx_pkg.
REQ-027 The bit-period counter SHALL be a sub-module tick_gen (parameter DIV; inputs clk, rst_n, run; output tick, one-cycle pulse every DIV cycles while run=1, counter cleared when run=0).
REQ-028 Shift register, bit counter and FSM SHALL reside in piso_tx.

Verification
REQ-029 WIDTH=8, DIV=12, load 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 each held 12 cycles; ser_frame high 96 cycles; done pulses once.
REQ-030 DIV=1, load 8'h81 -> ser_out 1,0,0,0,0,0,0,1 on consecutive cycles; done on cycle 9 after acceptance.
REQ-031 load_valid held high with data 8'hFF then 8'h00 -> second word accepted exactly WIDTH*DIV+2 cycles after first; load_data changes mid-frame do not alter ser_out.
REQ-032 rst_n pulsed low during bit 3 of 8'h3C -> outputs zero asynchronously, no done, next load 8'hC3 transmits correctly.
REQ-033 WIDTH=2, DIV=3, load 2'b10 -> ser_out 1 for 3 cycles, 0 for 3 cycles, then done=1 for one cycle.
REQ-034 Random back-to-back loads (1000 frames) -> scoreboard reconstructs every accepted word from ser_out sampled mid-bit while ser_frame=1.
